// File: rtl/net_sequencer_if.sv
// net_sequencer_if: control and status bundle between the layer scheduler and its host/engines.
interface net_sequencer_if #(
    parameter int NUM_LAYERS = 3,
    parameter int LAYER_W    = 2
);
    logic                  run;
    logic                  abort;
    logic [NUM_LAYERS-1:0] layer_done;
    logic [NUM_LAYERS-1:0] layer_start;
    logic [LAYER_W-1:0]    cur_layer;
    logic                  buf_sel;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [LAYER_W-1:0]    err_layer;

    modport master (
        output run, abort, layer_done,
        input  layer_start, cur_layer, buf_sel, busy, done, error, err_layer
    );

    modport slave (
        input  run, abort, layer_done,
        output layer_start, cur_layer, buf_sel, busy, done, error, err_layer
    );
endinterface

// File: rtl/net_sequencer.sv
// net_sequencer: starts each CNN layer engine in turn, flips the ping-pong buffer between
// layers, pulses done after the last layer, and traps hung layers with a watchdog.
module net_sequencer #(
    parameter int                NUM_LAYERS = 3,
    parameter int                LAYER_W    = 2,
    parameter int                TO_W       = 20,
    parameter logic [TO_W-1:0]   TIMEOUT    = 20'd600000
) (
    input  logic            clk,
    input  logic            rst_n,
    net_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_NEXT, S_FINISH, S_ERROR} state_t;

    state_t                r_state;
    logic [NUM_LAYERS-1:0] r_done_q;
    logic [NUM_LAYERS-1:0] r_layer_start;
    logic [LAYER_W-1:0]    r_cur;
    logic [LAYER_W-1:0]    r_err_layer;
    logic [TO_W-1:0]       r_timer;
    logic                  r_buf_sel;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic [NUM_LAYERS-1:0] w_sel;
    logic                  w_hit;
    logic                  w_last;

    // only a fresh rising edge on the active layer's flag completes it
    assign w_sel  = NUM_LAYERS'(1) << r_cur;
    assign w_hit  = |(bus.layer_done & ~r_done_q & w_sel);
    assign w_last = r_cur == LAYER_W'(NUM_LAYERS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_done_q      <= '0;
            r_layer_start <= '0;
            r_cur         <= '0;
            r_err_layer   <= '0;
            r_timer       <= '0;
            r_buf_sel     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_done_q      <= bus.layer_done;
            r_layer_start <= '0;
            r_done        <= 1'b0;
            if (bus.abort) begin
                r_state   <= S_IDLE;
                r_error   <= 1'b0;
                r_timer   <= '0;
                r_cur     <= '0;
                r_buf_sel <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_ERROR: begin
                        if (bus.run) begin
                            r_state       <= S_START;
                            r_cur         <= '0;
                            r_buf_sel     <= 1'b0;
                            r_error       <= 1'b0;
                            r_busy        <= 1'b1;
                            r_layer_start <= NUM_LAYERS'(1);
                        end
                    end
                    S_START: begin
                        r_timer <= '0;
                        r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (w_hit) begin
                            r_state <= S_NEXT;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                            if (|TIMEOUT && r_timer == TIMEOUT - 1'b1) begin
                                r_state     <= S_ERROR;
                                r_err_layer <= r_cur;
                                r_error     <= 1'b1;
                                r_busy      <= 1'b0;
                            end
                        end
                    end
                    S_NEXT: begin
                        r_buf_sel <= ~r_buf_sel;
                        if (w_last) begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_cur         <= r_cur + 1'b1;
                            r_state       <= S_START;
                            r_layer_start <= NUM_LAYERS'(1) << (r_cur + 1'b1);
                        end
                    end
                    S_FINISH: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.layer_start = r_layer_start;
    assign bus.cur_layer   = r_cur;
    assign bus.buf_sel     = r_buf_sel;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.error       = r_error;
    assign bus.err_layer   = r_err_layer;
endmodule

// File: tb/tb_net_sequencer.sv
// tb_net_sequencer: directed stimulus pushes expected start/done/error events into a queue;
// a negedge monitor pops and compares each event the sequencer presents.
module tb_net_sequencer;
    localparam int NL = 3;
    localparam int LW = 2;

    typedef struct {int code; int data; int bsel; int at;} ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   s;
    logic prev_err = 1'b0;
    ev_t  q[$];

    net_sequencer_if #(.NUM_LAYERS(NL), .LAYER_W(LW)) bus ();

    net_sequencer #(.NUM_LAYERS(NL), .LAYER_W(LW), .TO_W(20), .TIMEOUT(20'd16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string name);
        chk(name, {bus.layer_start, bus.cur_layer, bus.buf_sel, bus.busy, bus.done, bus.error, bus.err_layer}, 0);
    endtask

    task automatic exp_ev(input int code, input int data, input int bsel, input int at);
        q.push_back('{code, data, bsel, at});
    endtask

    // code 1 = layer_start (data=one-hot, bsel=buf_sel), 2 = done (data=cur_layer, bsel=buf_sel),
    // 3 = error rise (data=err_layer, bsel=busy)
    task automatic got(input int code, input int data, input int bsel);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got code %0d data %0d aux %0d at cycle %0d, expected none", code, data, bsel, cyc);
        end else begin
            e = q.pop_front();
            if (e.code != code || e.data != data || e.bsel != bsel || e.at != cyc) begin
                errors++;
                $display("FAIL event: got code %0d data %0d aux %0d cycle %0d, expected code %0d data %0d aux %0d cycle %0d",
                         code, data, bsel, cyc, e.code, e.data, e.bsel, e.at);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.layer_start != 0) got(1, int'(bus.layer_start), int'(bus.buf_sel));
            if (bus.done) got(2, int'(bus.cur_layer), int'(bus.buf_sel));
            if (bus.error && !prev_err) got(3, int'(bus.err_layer), int'(bus.busy));
        end
        prev_err = bus.error;
    end

    initial begin
        bus.run = 1'b0;
        bus.abort = 1'b0;
        bus.layer_done = '0;
        #2;
        chk_zero("reset_state");
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // nominal run with a spurious layer-2 edge and a run pulse while busy
        bus.run = 1'b1;
        exp_ev(1, 1, 0, cyc + 1);
        tick(1);
        bus.run = 1'b0;
        s = cyc;
        chk("busy_at_start", bus.busy, 1);
        tick(2);
        bus.run = 1'b1;
        bus.layer_done[2] = 1'b1;
        tick(1);
        bus.run = 1'b0;
        bus.layer_done[2] = 1'b0;
        tick(5);
        chk("spurious_cur", bus.cur_layer, 0);
        for (int l = 0; l < NL; l++) begin
            if (l > 0) tick(8);
            if (l < NL - 1) exp_ev(1, 1 << (l + 1), (l + 1) % 2, cyc + 2);
            else exp_ev(2, NL - 1, 1, cyc + 2);
            bus.layer_done[l] = 1'b1;
            tick(1);
            bus.layer_done[l] = 1'b0;
            tick(1);
            chk("busy_nominal", bus.busy, 1);
        end
        tick(1);
        chk("busy_after_done", bus.busy, 0);
        chk("cur_final", bus.cur_layer, NL - 1);
        chk("buf_final", bus.buf_sel, 1);

        // level done held from before run must not complete layer 0
        bus.layer_done[0] = 1'b1;
        tick(3);
        bus.run = 1'b1;
        exp_ev(1, 1, 0, cyc + 1);
        tick(1);
        bus.run = 1'b0;
        tick(4);
        bus.layer_done[0] = 1'b0;
        tick(2);
        chk("level_hold", bus.cur_layer, 0);
        tick(4);
        exp_ev(1, 2, 1, cyc + 2);
        bus.layer_done[0] = 1'b1;
        tick(2);
        s = cyc;
        chk("level_advance", bus.cur_layer, 1);

        // watchdog on layer 1
        exp_ev(3, 1, 0, s + 17);
        tick(17);
        chk("wd_error", bus.error, 1);
        chk("wd_err_layer", bus.err_layer, 1);
        chk("wd_busy", bus.busy, 0);
        bus.layer_done[0] = 1'b0;
        bus.run = 1'b1;
        exp_ev(1, 1, 0, cyc + 1);
        tick(1);
        bus.run = 1'b0;
        s = cyc;
        chk("restart_error", bus.error, 0);
        chk("restart_cur", bus.cur_layer, 0);

        // done edge on the timeout cycle wins
        tick(16);
        exp_ev(1, 2, 1, cyc + 2);
        bus.layer_done[0] = 1'b1;
        tick(1);
        bus.layer_done[0] = 1'b0;
        tick(1);
        s = cyc;
        chk("coincident_error", bus.error, 0);
        chk("coincident_cur", bus.cur_layer, 1);

        // abort beats run while in ERROR
        exp_ev(3, 1, 0, s + 17);
        tick(17);
        chk("abort_pre_error", bus.error, 1);
        bus.abort = 1'b1;
        bus.run = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        bus.run = 1'b0;
        chk("abort_state", {bus.error, bus.busy, bus.cur_layer, bus.buf_sel}, 0);
        tick(4);

        // asynchronous reset while waiting on layer 1
        bus.run = 1'b1;
        exp_ev(1, 1, 0, cyc + 1);
        tick(1);
        bus.run = 1'b0;
        tick(4);
        exp_ev(1, 2, 1, cyc + 2);
        bus.layer_done[0] = 1'b1;
        tick(1);
        bus.layer_done[0] = 1'b0;
        tick(4);
        chk("pre_reset_cur", bus.cur_layer, 1);
        rst_n = 1'b0;
        #1;
        chk_zero("reset_mid_wait");
        tick(2);
        rst_n = 1'b1;
        tick(6);

        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/net_sequencer.md
Name: net_sequencer

Overview:
Top-level layer scheduler for the CNN datapath. It starts each layer engine in turn with a one-cycle start pulse and waits for that layer's completion (the layer's output-channel-complete flag). It toggles the ping-pong feature-map buffer select between layers and pulses done when the final layer finishes. A per-layer watchdog detects hung layers, and an abort input returns the block to idle.

Parameters:
NUM_LAYERS, 3, number of sequenced layer engines (≥1)
LAYER_W, 2, width of layer index; 2**LAYER_W ≥ NUM_LAYERS
TO_W, 20, watchdog counter width
TIMEOUT, 20'd600000, max cycles in WAIT per layer; 0 disables the watchdog

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  start-network request; sampled only in IDLE or ERROR
abort  input  1  synchronous abort; highest priority
layer_done  input  NUM_LAYERS  per-layer completion (level or pulse); only rising edges count
layer_start  output  NUM_LAYERS  one-hot, one-cycle start pulse to layer cur_layer
cur_layer  output  LAYER_W  index of the active layer
buf_sel  output  1  ping-pong select: 0 = read buffer A / write buffer B, 1 = the opposite
busy  output  1  high in START, WAIT, NEXT, FINISH
done  output  1  one-cycle pulse after the last layer completes
error  output  1  watchdog tripped; held until cleared
err_layer  output  LAYER_W  layer index captured at the watchdog trip

Behaviour:
- Reset (async, rst_n=0): state=IDLE; layer_start=0, cur_layer=0, buf_sel=0, busy=0, done=0, error=0, err_layer=0, timer=0, done_q=0.
- All outputs are Moore/registered. No combinational path from input to output.
- Edge detect: done_q <= layer_done every cycle in every state. edge[k] = layer_done[k] & ~done_q[k].
- Abort handling: abort=1 at any edge forces IDLE and clears error, timer, cur_layer, and buf_sel. This wins over run and over a simultaneous done edge.
- FSM states: IDLE, START, WAIT, NEXT, FINISH, ERROR.
- IDLE: when run=1, go to START with cur_layer=0 and buf_sel=0.
- START: lasts exactly 1 cycle. layer_start[cur_layer]=1. timer cleared. Next state is WAIT.
- WAIT:
  - edge[cur_layer] → NEXT.
  - Otherwise timer+1. If TIMEOUT≠0 and timer==TIMEOUT-1 → ERROR, with err_layer=cur_layer.
  - Edges on other layer bits are ignored.
  - A done edge arriving in the same cycle as the timeout goes to NEXT (done wins).
- NEXT: buf_sel toggles. If cur_layer==NUM_LAYERS-1 → FINISH. Otherwise cur_layer+1 and → START.
- FINISH: done=1 for 1 cycle, then → IDLE. cur_layer holds its final value until the next run.
- ERROR: error=1 and busy=0. run=1 clears error and restarts as from IDLE. abort → IDLE.
- run while busy is ignored; there is no queued restart.
- Latency:
  - run sampled at edge E0 → layer_start[0] high for cycle E0..E1.
  - Done edge sampled at E → next layer_start high for cycle E+1..E+2.
  - Last-layer edge sampled at E → done high for cycle E+1..E+2. busy drops at E+2.
- buf_sel toggles exactly NUM_LAYERS times per completed run. For odd NUM_LAYERS it ends at 1; the next run re-initialises it to 0.
- NUM_LAYERS=1: the path is START → WAIT → NEXT → FINISH, with no index increment.
- A rising edge is never generated internally. A layer_done held high from a prior run does not advance WAIT until it falls and rises again.

Test Plan:
- Reset mid-WAIT: rst_n=0 while cur_layer=1 → all outputs 0 immediately (asynchronously); no layer_start after release.
- Nominal run, NUM_LAYERS=3, each layer_done pulses 50 cycles after its start:
  - layer_start sequence is 001, 010, 100, each 1 cycle wide.
  - Each start comes 2 cycles after the prior done edge.
  - buf_sel sequence is 0, 1, 0, 1.
  - done pulses once; busy covers start through done.
- Level done: layer_done[0] held high from before run → layer 0 does not complete. Drop it, then raise it 20 cycles after start → advance.
- Watchdog: TIMEOUT=16, layer 1 never completes → ERROR 16 cycles after WAIT entry; error=1, err_layer=1, busy=0. A run pulse then restarts at layer 0 with error=0.
- Simultaneous events:
  - Done edge on the timeout cycle → NEXT, error stays 0.
  - abort and run in the same cycle while in ERROR → IDLE, error=0, no layer_start.
- Spurious edges: layer_done[2] pulses while waiting on layer 0 → ignored, cur_layer stays 0. run pulses while busy → no effect.
